// File: rtl/proc_pkg.sv
// Shared definitions for the fetch stage feeding the 4-bit Control core.
package proc_pkg;

  localparam int OPC_W  = 4;               // opcode width (core instr)
  localparam int OPND_W = 4;               // operand width (core portin)
  localparam int WORD_W = OPND_W + OPC_W;  // packed program word

  // Program word field positions: [7:4] operand, [3:0] opcode
  localparam int OPC_LSB  = 0;
  localparam int OPND_LSB = OPC_W;

  localparam logic [OPC_W-1:0] HALT_OP_DEF = 4'b1111;
  localparam logic [OPC_W-1:0] NOP_OP_DEF  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [OPND_W-1:0] operand;
    logic [OPC_W-1:0]  opcode;
  } prog_word_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x WORD_W, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives rst.
module prog_mem
  import proc_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Autonomous fetch stage: issues one program word per clock to the core,
// honours core jumps, stall back-pressure, halt opcode and end of memory.
// DEPTH must equal 2**ADDR_W so that pc arithmetic wraps naturally.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int               ADDR_W  = 4,
  parameter int               DEPTH   = 16,
  parameter logic [OPC_W-1:0] HALT_OP = HALT_OP_DEF,
  parameter logic [OPC_W-1:0] NOP_OP  = NOP_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              start,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [OPC_W-1:0]  instr,
  output logic [OPND_W-1:0] portin,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OPC_W-1:0]  instr_q, instr_d;
  logic [OPND_W-1:0] portin_q, portin_d;
  logic              valid_q, valid_d;
  // Set when the word currently issued came from the last address
  logic              last_q, last_d;

  logic              idle_or_done;
  logic              mem_we;
  logic              do_start;
  logic              run_adv;
  logic              at_end;
  logic              do_jump;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] mem_rdata;
  prog_word_t        fetch_word;

  assign idle_or_done = (state_q != RUN);
  assign mem_we       = ld_en & idle_or_done & ~rst;
  assign do_start     = start & idle_or_done;
  assign run_adv      = (state_q == RUN) & ~stall;
  // Halt word or end of memory consumes the next unstalled edge; this beats
  // any jump the core requests on that edge.
  assign at_end       = (instr_q == HALT_OP) | last_q;
  assign do_jump      = run_adv & ~at_end & jmp_en;

  assign rd_addr = do_start ? '0 : (do_jump ? jmp_addr : pc_q);

  prog_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .raddr_i (rd_addr),
    .rdata_o (mem_rdata)
  );

  // Write-first bypass: a load and start in the same cycle issue the new word
  assign fetch_word = (mem_we && (ld_addr == rd_addr)) ? prog_word_t'(ld_data)
                                                        : prog_word_t'(mem_rdata);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_OP;
      portin_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      portin_q <= portin_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (do_start) state_d = RUN;
      RUN:        if (run_adv && at_end) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next values: issue a word, retire on halt/end, or hold
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    portin_d = portin_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (do_start || (run_adv && !at_end)) begin
      instr_d  = fetch_word.opcode;
      portin_d = fetch_word.operand;
      valid_d  = 1'b1;
      pc_d     = rd_addr + ADDR_W'(1);
      last_d   = (rd_addr == LAST_ADDR);
    end else if (run_adv && at_end) begin
      instr_d = NOP_OP;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign instr  = instr_q;
  assign portin = portin_q;
  assign valid  = valid_q;
  assign pc     = pc_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: straight-line, jump, stall, reset,
// load gating and end-of-memory wrap scenarios.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst, ld_en, start, stall, jmp_en;
  logic [3:0] ld_addr, jmp_addr, instr, portin, pc;
  logic [7:0] ld_data;
  logic       valid, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] prog      [11] = '{8'h09, 8'h36, 8'h04, 8'h36, 8'h14, 8'h05,
                                 8'h08, 8'h15, 8'h00, 8'h07, 8'h0F};
  logic [3:0] exp_instr [11] = '{4'h9, 4'h6, 4'h4, 4'h6, 4'h4, 4'h5,
                                 4'h8, 4'h5, 4'h0, 4'h7, 4'hF};
  logic [3:0] exp_port  [11] = '{4'd0, 4'd3, 4'd0, 4'd3, 4'd1, 4'd0,
                                 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};

  instr_fetch dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .stall(stall), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .instr(instr), .portin(portin), .valid(valid), .pc(pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Bounded wait for DONE; an expired bound is a failed comparison
  task automatic wait_done(input string tag);
    for (int k = 0; k < 40 && !done; k++) step();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL %s_done: got done=%b want 1", tag, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total_cnt++;
    if ({valid, instr, portin, pc, busy, done} !== {1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset_vals: got v=%b i=%h p=%h pc=%0d b=%b d=%b want 0,0,0,0,0,0",
               valid, instr, portin, pc, busy, done);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_straight();
    for (int i = 0; i < 11; i++) load_word(4'(i), prog[i]);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total_cnt++;
      if ({valid, busy, instr, portin, pc} !== {1'b1, 1'b1, exp_instr[i], exp_port[i], 4'(i + 1)})
        $display("FAIL straight_w%0d: got v=%b b=%b i=%h p=%h pc=%0d want v=1 b=1 i=%h p=%h pc=%0d",
                 i, valid, busy, instr, portin, pc, exp_instr[i], exp_port[i], i + 1);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({valid, done, busy, instr, pc} !== {1'b0, 1'b1, 1'b0, 4'h0, 4'd11})
      $display("FAIL straight_halt: got v=%b d=%b b=%b i=%h pc=%0d want v=0 d=1 b=0 i=0 pc=11",
               valid, done, busy, instr, pc);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    logic [3:0] ei [3] = '{4'h0, 4'h7, 4'hF};
    logic [3:0] ep [3] = '{4'd9, 4'd10, 4'd11};
    start = 1'b1; step(); start = 1'b0;   // word 0
    step();                               // word 1
    step();                               // word 2
    total_cnt++;
    if ({instr, pc} !== {4'h4, 4'd3})
      $display("FAIL jump_pre: got i=%h pc=%0d want i=4 pc=3", instr, pc);
    else pass_cnt++;
    jmp_en = 1'b1; jmp_addr = 4'd8;
    step();
    jmp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({valid, instr, pc} !== {1'b1, ei[i], ep[i]})
        $display("FAIL jump_seq%0d: got v=%b i=%h pc=%0d want v=1 i=%h pc=%0d",
                 i, valid, instr, pc, ei[i], ep[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({done, valid, pc} !== {1'b1, 1'b0, 4'd11})
      $display("FAIL jump_halt: got d=%b v=%b pc=%0d want d=1 v=0 pc=11", done, valid, pc);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    start = 1'b1; step(); start = 1'b0;   // word 0
    step();                               // word 1 (instr 6)
    stall = 1'b1; jmp_en = 1'b1; jmp_addr = 4'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({valid, instr, portin, pc} !== {1'b1, 4'h6, 4'h3, 4'd2})
        $display("FAIL stall_hold%0d: got v=%b i=%h p=%h pc=%0d want v=1 i=6 p=3 pc=2",
                 i, valid, instr, portin, pc);
      else pass_cnt++;
    end
    stall = 1'b0; jmp_en = 1'b0;
    step();
    total_cnt++;
    if ({instr, portin, pc} !== {4'h4, 4'h0, 4'd3})
      $display("FAIL stall_resume: got i=%h p=%h pc=%0d want i=4 p=0 pc=3", instr, portin, pc);
    else pass_cnt++;
    wait_done("stall");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; step(); start = 1'b0;   // word 0
    step(); step();                       // word 2 = 3rd issued
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({valid, instr, pc, busy, done} !== {1'b0, 4'h0, 4'd0, 1'b0, 1'b0})
      $display("FAIL midrun_reset: got v=%b i=%h pc=%0d b=%b d=%b want 0,0,0,0,0",
               valid, instr, pc, busy, done);
    else pass_cnt++;
    start = 1'b1; step(); start = 1'b0;
    total_cnt++;
    if ({valid, instr, portin, pc} !== {1'b1, 4'h9, 4'h0, 4'd1})
      $display("FAIL midrun_restart: got v=%b i=%h p=%h pc=%0d want v=1 i=9 p=0 pc=1",
               valid, instr, portin, pc);
    else pass_cnt++;
  endtask

  // Entered in RUN with word 0 issued
  task automatic test_load_gating();
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 8'hFF; start = 1'b1;
    step();
    ld_en = 1'b0; start = 1'b0;
    total_cnt++;
    if ({busy, instr, portin, pc} !== {1'b1, 4'h6, 4'h3, 4'd2})
      $display("FAIL gate_norestart: got b=%b i=%h p=%h pc=%0d want b=1 i=6 p=3 pc=2",
               busy, instr, portin, pc);
    else pass_cnt++;
    wait_done("gate1");
    start = 1'b1; step(); start = 1'b0;
    total_cnt++;
    if ({instr, portin} !== {4'h9, 4'h0})
      $display("FAIL gate_memkept: got i=%h p=%h want i=9 p=0", instr, portin);
    else pass_cnt++;
    wait_done("gate2");
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 8'h5A; start = 1'b1;
    step();
    ld_en = 1'b0; start = 1'b0;
    total_cnt++;
    if ({valid, instr, portin, pc} !== {1'b1, 4'hA, 4'h5, 4'd1})
      $display("FAIL gate_ldstart: got v=%b i=%h p=%h pc=%0d want v=1 i=a p=5 pc=1",
               valid, instr, portin, pc);
    else pass_cnt++;
    wait_done("gate3");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'h01);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if ({valid, instr, pc} !== {1'b1, 4'h1, 4'((i + 1) % 16)})
        $display("FAIL wrap_w%0d: got v=%b i=%h pc=%0d want v=1 i=1 pc=%0d",
                 i, valid, instr, pc, (i + 1) % 16);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({done, valid, pc} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL wrap_end: got d=%b v=%b pc=%0d want d=1 v=0 pc=0", done, valid, pc);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done, valid, pc} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL wrap_stay: got d=%b v=%b pc=%0d want d=1 v=0 pc=0", done, valid, pc);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
    test_reset();
    test_straight();
    test_jump();
    test_stall();
    test_reset_mid_run();
    test_load_gating();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program sequencer that sits directly upstream of the 4-bit `Control` processor core.
- Holds a small loadable program memory. Each word packs an operand for the core's `portin` and an opcode for its `instr`.
- Issues one word per clock to the core and supports jumps requested by the core, stall and halt.
- Replaces hand-driven `portin`/`instr` stimulus with an autonomous fetch stage.

Parameters:
- ADDR_W, 4, program address width.
- DEPTH, 16, number of program words; must equal 2**ADDR_W.
- HALT_OP, 4'b1111, opcode that ends the program. The halt word itself is still issued.
- NOP_OP, 4'b0000, value driven on `instr` whenever `valid` = 0.

Ports:
- clk, in, 1, single system clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- ld_en, in, 1, program write strobe; honoured only in IDLE or DONE.
- ld_addr, in, ADDR_W, program write address.
- ld_data, in, 8, program word: [7:4] operand, [3:0] opcode.
- start, in, 1, begin execution at address 0; honoured only in IDLE or DONE.
- stall, in, 1, core back-pressure; holds the issued word and `pc`.
- jmp_en, in, 1, core requests a jump.
- jmp_addr, in, ADDR_W, jump target.
- instr, out, 4, opcode to core `instr`.
- portin, out, 4, operand to core `portin`.
- valid, out, 1, `instr`/`portin` carry a live program word this cycle.
- pc, out, ADDR_W, address of the next word to fetch.
- busy, out, 1, high in RUN.
- done, out, 1, high in DONE.

Behaviour:
- Memory: DEPTH x 8 array. Synchronous write when `ld_en` is high in IDLE or DONE. Asynchronous read at `pc` (or at `jmp_addr` on a jump). Memory is not cleared by reset.
- Outputs `instr`, `portin` and `valid` are registered.
- Reset values: state IDLE, `pc` = 0, `instr` = NOP_OP, `portin` = 0, `valid` = 0, `busy` = 0, `done` = 0.
- `rst` overrides everything, including mid-RUN; the next cycle shows the reset values.
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start` = 1 at an edge:
  - state -> RUN;
  - {`portin`, `instr`} <= mem[0], `valid` <= 1, `pc` <= 1, `done` <= 0.
  - Latency: first word appears one cycle after `start` is sampled.
- If `ld_en` and `start` are both high in the same IDLE/DONE cycle, the write completes first. Writing address 0 in that cycle therefore issues the new data.
- RUN, `stall` = 1: outputs and `pc` hold. `jmp_en` is ignored (stall has priority).
- RUN, `stall` = 0, `jmp_en` = 1: issue mem[`jmp_addr`], `pc` <= `jmp_addr` + 1 (mod DEPTH). No bubble.
- RUN, `stall` = 0, `jmp_en` = 0: issue mem[`pc`], `pc` <= `pc` + 1.
- Halt: when the word just issued has opcode == HALT_OP and `stall` = 0 on the following edge:
  - state -> DONE;
  - `valid` <= 0, `instr` <= NOP_OP, `portin` holds;
  - `pc` holds.
- Wrap-around: issuing address DEPTH-1 without a jump makes `pc` = 0. On the next unstalled edge, state -> DONE exactly as for halt; `pc` holds at 0. There is no silent wrap-around execution.
- If a jump targets DEPTH-1, the same end-of-memory rule applies after that word.
- A jump issued together with the HALT_OP word is not possible: `jmp_en` is evaluated on the edge that would consume the halt, and halt takes priority over the jump.
- `start` and `ld_en` are ignored in RUN.
- `busy` = (state == RUN); `done` = (state == DONE). Both are registered with the state.

Decomposition:
- Shared package (`proc_pkg`):
  - opcode width (4), operand width (4);
  - HALT_OP and NOP_OP defaults;
  - fetch state enum {IDLE, RUN, DONE};
  - program-word field positions.
- One natural sub-module: `prog_mem`, the DEPTH x 8 array with synchronous write and asynchronous read.
- The FSM, PC and output register stay in `instr_fetch`.

Test Plan:
- Reset mid-RUN: assert `rst` at the 3rd issued word -> next cycle `valid` = 0, `instr` = 0000, `pc` = 0, `busy` = 0. Memory contents survive: a restart re-issues word 0.
- Straight-line program: load words 0x09, 0x36, 0x04, 0x36, 0x14, 0x05, 0x08, 0x15, 0x00, 0x07, 0x0F; pulse `start` -> one word per cycle with `instr` = 9,6,4,6,4,5,8,5,0,7,F and `portin` = 0,3,0,3,1,0,0,1,0,0,0. The cycle after F: `valid` = 0, `done` = 1, `pc` = 11.
- Jump: same program; `jmp_en` = 1 with `jmp_addr` = 8 on the cycle word 2 is valid -> next word is 0x00 from address 8, then 0x07, 0x0F; `pc` sequence 3 -> 9 -> 10 -> 11.
- Stall: hold `stall` = 1 for 3 cycles while `instr` = 6 (address 1), with `jmp_en` = 1 during the stall -> outputs and `pc` = 2 frozen, jump ignored; the sequence resumes at address 2.
- Wrap: fill all 16 words with 0x01 (no halt), `start` -> 16 valid cycles, then `done` = 1, `pc` = 0, `valid` = 0.
- Load gating: `ld_en` to address 0 with 0xFF during RUN -> memory unchanged. `start` pulsed during RUN -> no restart. In DONE, load then `start` in the same cycle -> first issued word is the new data.
